truth_table_scanner: RTL

Sequential stimulus/response engine placed around a combinational Boolean-expression stage. On request, it sweeps every input combination into the expression and samples the expression's output `f` for each combination. The sampled truth table is compared against an expected minterm mask, and the block reports a pass/fail result. It replaces the hand-written `for` loops in the benches with synthesizable hardware, so expression blocks can be self-checked on the board.

---
 rtl/truth_table_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/truth_table_scanner.sv
// Sweeps every input vector into a combinational expression, samples f_in and
// compares against an expected minterm mask. Optional macro: SCANNER_FAIL_STOP_EN.
module truth_table_scanner #(
  parameter int unsigned N_IN   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [(1<<N_IN)-1:0]   expected,
  input  logic                   f_in,
  output logic [N_IN-1:0]        vec_out,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [(1<<N_IN)-1:0]   captured,
  output logic [N_IN:0]          mismatch_count,
  output logic [N_IN-1:0]        first_fail
);

  localparam int unsigned NV = 1 << N_IN;
  localparam int unsigned VW = N_IN;
  localparam int unsigned CW = N_IN + 1;
  localparam int unsigned SW = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE} state_t;

  state_t        state, state_d;
  logic [SW-1:0] cnt, cnt_d;
  logic [VW-1:0] vec_d, ff_d;
  logic          busy_d, done_d, pass_d;
  logic [NV-1:0] captured_d;
  logic [CW-1:0] mc_d;
  logic          miss, last, stop;

  // State and all registered outputs; reset discards any partial scan
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= IDLE;
      cnt            <= '0;
      vec_out        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      captured       <= '0;
      mismatch_count <= '0;
      first_fail     <= '0;
    end else begin
      state          <= state_d;
      cnt            <= cnt_d;
      vec_out        <= vec_d;
      busy           <= busy_d;
      done           <= done_d;
      pass           <= pass_d;
      captured       <= captured_d;
      mismatch_count <= mc_d;
      first_fail     <= ff_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    vec_d      = vec_out;
    busy_d     = busy;
    done_d     = 1'b0;
    pass_d     = pass;
    captured_d = captured;
    mc_d       = mismatch_count;
    ff_d       = first_fail;
    miss       = (f_in != expected[vec_out]);
    last       = (vec_out == VW'(NV - 1));
    stop       = last;

    case (state)
      IDLE: begin
        busy_d = 1'b0;
        vec_d  = '0;
        if (start) begin
          state_d    = DRIVE;
          busy_d     = 1'b1;
          cnt_d      = '0;
          captured_d = '0;
          mc_d       = '0;
          ff_d       = '0;
          pass_d     = 1'b0;
        end
      end
      DRIVE: begin
        if (cnt == SW'(SETTLE - 1)) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt + SW'(1);
        end
      end
      SAMPLE: begin
        captured_d[vec_out] = f_in;
        if (miss) begin
          mc_d = mismatch_count + CW'(1);
          if (mismatch_count == '0) begin
            ff_d = vec_out;
          end
        end
`ifdef SCANNER_FAIL_STOP_EN
        stop = last || miss;
`else
        stop = last;
`endif
        if (stop) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          vec_d   = '0;
          pass_d  = (mc_d == '0);
        end else begin
          state_d = DRIVE;
          vec_d   = vec_out + VW'(1);
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule
